// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one pipeline payload between stages.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 160
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline latch between stages: valid/ready handshake, optional 2-entry skid buffer,
// flush, bubble clearing and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int DATA_W  = 160,
  parameter bit SKID    = 1'b1,
  parameter bit CLR_BUB = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn,
  output logic [1:0]         occupancy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_p1, main_d;
  logic [DATA_W-1:0] skid_p1, skid_d;
  logic              out_valid;
  logic              in_xfer, out_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign out_valid = (state_q != EMPTY);
  assign dn.valid  = out_valid;
  assign dn.data   = main_p1;
  assign in_xfer   = up.valid && up.ready;
  assign out_xfer  = out_valid && dn.ready;

  if (SKID) begin : g_skid
    logic in_ready_q;
    // Registered ready breaks the combinational path from downstream ready back upstream.
    always_ff @(posedge clk) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= (state_d != FULL);
    end
    assign up.ready = in_ready_q;
  end else begin : g_noskid
    assign up.ready = !out_valid || dn.ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_p1;
    skid_d  = skid_p1;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = up.data;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d = FULL;
          skid_d  = up.data;
        end else if (in_xfer && out_xfer) begin
          main_d = up.data;
        end else if (out_xfer) begin
          state_d = EMPTY;
          if (CLR_BUB) main_d = '0;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_p1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything held and any incoming payload; an OUT this cycle already happened.
    if (flush) begin
      state_d = EMPTY;
      main_d  = CLR_BUB ? '0 : main_p1;
      skid_d  = CLR_BUB ? '0 : skid_p1;
    end
  end

  // Stage p1: state, head payload, occupancy and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      occupancy <= 2'd0;
      main_p1   <= '0;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      occupancy <= occ_of(state_d);
      main_p1   <= main_d;
      if (cnt_clr)                 stall_cnt <= '0;
      else if (out_valid && !dn.ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    skid_p1 <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations driven in lockstep against a FIFO reference model.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
  localparam int DW = 160;
  localparam int N  = 3;   // 0: SKID=1 CLR_BUB=1 CNT_W=32, 1: SKID=0, 2: SKID=1 CLR_BUB=0 CNT_W=3

  logic clk = 1'b0;
  logic rst;
  logic          in_valid[N], out_ready[N], flush[N], cnt_clr[N];
  logic [DW-1:0] in_data[N];
  logic          in_ready[N], out_valid[N];
  logic [DW-1:0] out_data[N];
  logic [1:0]    occupancy[N];
  logic [31:0]   stall_cnt[N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam bit SK = (g != 1);
    localparam bit CB = (g != 2);
    localparam int CW = (g == 2) ? 3 : 32;
    pipe_stage_skid_if #(.DATA_W(DW)) up ();
    pipe_stage_skid_if #(.DATA_W(DW)) dn ();
    logic [CW-1:0] cnt;
    assign up.valid     = in_valid[g];
    assign up.data      = in_data[g];
    assign in_ready[g]  = up.ready;
    assign out_valid[g] = dn.valid;
    assign out_data[g]  = dn.data;
    assign dn.ready     = out_ready[g];
    assign stall_cnt[g] = 32'(cnt);
    pipe_stage_skid #(.DATA_W(DW), .SKID(SK), .CLR_BUB(CB), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]), .up(up.slave), .dn(dn.master),
      .occupancy(occupancy[g]), .cnt_clr(cnt_clr[g]), .stall_cnt(cnt));
  end

  // Reference model: a bounded FIFO plus the last head value shown.
  logic [DW-1:0] mf[N][2];
  int            msz[N];
  logic [DW-1:0] mlast[N];
  longint        mcnt[N];

  function automatic bit cfg_skid(int i);   return i != 1; endfunction
  function automatic bit cfg_clrbub(int i); return i != 2; endfunction
  function automatic longint cfg_max(int i); return (i == 2) ? 64'd7 : 64'hFFFF_FFFF; endfunction

  function automatic bit exp_ready(int i);
    return cfg_skid(i) ? (msz[i] < 2) : (msz[i] == 0 || out_ready[i]);
  endfunction

  function automatic logic [DW-1:0] exp_data(int i);
    if (msz[i] > 0) return mf[i][0];
    return cfg_clrbub(i) ? '0 : mlast[i];
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = v;
      in_data[i]   = v ? d : {DW{1'bx}};
      out_ready[i] = r;
      flush[i]     = f;
      cnt_clr[i]   = c;
    end
  endtask

  task automatic tick();
    bit inx[N], outx[N], stl[N];
    for (int i = 0; i < N; i++) begin
      inx[i]  = in_valid[i] && exp_ready(i);
      outx[i] = (msz[i] > 0) && out_ready[i];
      stl[i]  = (msz[i] > 0) && !out_ready[i];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        msz[i] = 0; mlast[i] = '0; mcnt[i] = 0;
      end else begin
        if (cnt_clr[i]) mcnt[i] = 0;
        else if (stl[i] && mcnt[i] < cfg_max(i)) mcnt[i]++;
        if (outx[i]) begin mf[i][0] = mf[i][1]; msz[i]--; end
        if (flush[i]) msz[i] = 0;
        else if (inx[i]) begin mf[i][msz[i]] = in_data[i]; msz[i]++; end
        if (msz[i] > 0) mlast[i] = mf[i][0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      checks++; if (out_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %0b want 0", i, out_valid[i]); end
      checks++; if (out_data[i] !== '0) begin errors++; $display("FAIL reset_data[%0d] got %h want 0", i, out_data[i]); end
      checks++; if (occupancy[i] !== 2'd0) begin errors++; $display("FAIL reset_occ[%0d] got %0d want 0", i, occupancy[i]); end
      checks++; if (stall_cnt[i] !== 32'd0) begin errors++; $display("FAIL reset_cnt[%0d] got %0d want 0", i, stall_cnt[i]); end
      checks++; if (in_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %0b want 1", i, in_ready[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      drive(1, DW'(k), 1, 0, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++; if (out_valid[i] !== 1'b1 || out_data[i] !== DW'(k)) begin
          errors++; $display("FAIL stream_out[%0d] got v=%0b d=%0h want v=1 d=%0h", i, out_valid[i], out_data[i], k); end
        checks++; if (occupancy[i] !== 2'd1 || stall_cnt[i] !== 32'd0 || in_ready[i] !== 1'b1) begin
          errors++; $display("FAIL stream_ctl[%0d] got occ=%0d cnt=%0d rdy=%0b want 1 0 1", i, occupancy[i], stall_cnt[i], in_ready[i]); end
      end
    end
    drive(0, '0, 1, 0, 0);
    tick();
    checks++; if (out_valid[0] !== 1'b0 || out_data[0] !== '0) begin
      errors++; $display("FAIL stream_drain got v=%0b d=%h want v=0 d=0", out_valid[0], out_data[0]); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] a, b, c;
    logic [DW-1:0] got[$];
    logic [DW-1:0] want[3];
    bit c_sent;
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    want = '{a, b, c};
    c_sent = 1'b0;
    drive(1, a, 1, 0, 0); tick();
    checks++; if (occupancy[0] !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d want 1", occupancy[0]); end
    drive(1, b, 0, 0, 0); tick();
    drive(1, c, 0, 0, 0); tick(); tick();
    checks++; if (occupancy[0] !== 2'd2 || in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_full got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy[0], in_ready[0]); end
    checks++; if (out_data[0] !== a) begin errors++; $display("FAIL bp_head got %h want %h", out_data[0], a); end
    for (int k = 0; k < 6; k++) begin
      drive(!c_sent, c, 1, 0, 0);
      #1;
      if (out_valid[0]) got.push_back(out_data[0]);
      if (!c_sent && in_ready[0]) c_sent = 1'b1;
      tick();
    end
    checks++; if (!c_sent) begin errors++; $display("FAIL bp_c_accepted got 0 want 1"); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== want[k]) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], want[k]); end
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] d1, d2, d3;
    d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
    drive(1, d1, 1, 0, 0); tick();
    drive(1, d2, 1, 0, 0); tick();
    checks++; if (out_data[0] !== d2 || out_data[2] !== d2) begin
      errors++; $display("FAIL bubble_pre got %h / %h want %h", out_data[0], out_data[2], d2); end
    drive(0, '0, 1, 0, 0); tick();
    checks++; if (out_valid[0] !== 1'b0 || out_data[0] !== '0) begin
      errors++; $display("FAIL bubble_clr got v=%0b d=%h want v=0 d=0", out_valid[0], out_data[0]); end
    checks++; if (out_valid[2] !== 1'b0 || out_data[2] !== d2) begin
      errors++; $display("FAIL bubble_hold got v=%0b d=%h want v=0 d=%h", out_valid[2], out_data[2], d2); end
    drive(1, d3, 1, 0, 0); tick();
    checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== d3) begin
      errors++; $display("FAIL bubble_post got v=%0b d=%h want v=1 d=%h", out_valid[0], out_data[0], d3); end
    drive(0, '0, 1, 0, 0); tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] a, b, d;
    a = rnd_data(); b = rnd_data(); d = rnd_data();
    drive(1, a, 0, 0, 0); tick();
    drive(1, b, 0, 0, 0); tick();
    drive(1, d, 1, 1, 0); #1;
    checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== a) begin
      errors++; $display("FAIL flush_head got v=%0b d=%h want v=1 d=%h", out_valid[0], out_data[0], a); end
    tick();
    drive(0, '0, 1, 0, 0); #1;
    checks++; if (out_valid[0] !== 1'b0 || occupancy[0] !== 2'd0 || in_ready[0] !== 1'b1 || out_data[0] !== '0) begin
      errors++; $display("FAIL flush_after got v=%0b occ=%0d rdy=%0b d=%h want 0 0 1 0",
                         out_valid[0], occupancy[0], in_ready[0], out_data[0]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        checks++; if (out_valid[i] !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got v=1 d=%h want v=0", i, out_data[i]); end
      end
    end
  endtask

  task automatic test_counter();
    drive(1, rnd_data(), 0, 0, 1); tick();
    checks++; if (stall_cnt[0] !== 32'd0 || stall_cnt[2] !== 32'd0) begin
      errors++; $display("FAIL cnt_start got %0d / %0d want 0", stall_cnt[0], stall_cnt[2]); end
    drive(0, '0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        checks++; if (stall_cnt[0] !== 32'd5) begin errors++; $display("FAIL cnt_five got %0d want 5", stall_cnt[0]); end
      end
    end
    checks++; if (stall_cnt[0] !== 32'd10) begin errors++; $display("FAIL cnt_ten got %0d want 10", stall_cnt[0]); end
    checks++; if (stall_cnt[2] !== 32'd7) begin errors++; $display("FAIL cnt_sat got %0d want 7", stall_cnt[2]); end
    drive(0, '0, 0, 0, 1); tick();
    checks++; if (stall_cnt[0] !== 32'd0 || stall_cnt[2] !== 32'd0) begin
      errors++; $display("FAIL cnt_clr got %0d / %0d want 0", stall_cnt[0], stall_cnt[2]); end
    drive(0, '0, 1, 0, 0); tick();
  endtask

  task automatic test_reset_full();
    drive(1, rnd_data(), 0, 0, 0); tick();
    drive(1, rnd_data(), 0, 0, 0); tick();
    checks++; if (occupancy[0] !== 2'd2) begin errors++; $display("FAIL rstfull_pre got occ=%0d want 2", occupancy[0]); end
    rst = 1'b1;
    drive(0, '0, 0, 0, 0); tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (out_valid[i] !== 1'b0 || out_data[i] !== '0 || occupancy[i] !== 2'd0 || stall_cnt[i] !== 32'd0) begin
        errors++; $display("FAIL rstfull[%0d] got v=%0b d=%h occ=%0d cnt=%0d want all 0",
                           i, out_valid[i], out_data[i], occupancy[i], stall_cnt[i]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = ($urandom_range(3) != 0);
        in_data[i]   = in_valid[i] ? rnd_data() : {DW{1'bx}};
        out_ready[i] = ($urandom_range(2) != 0);
        flush[i]     = ($urandom_range(24) == 0);
        cnt_clr[i]   = ($urandom_range(39) == 0);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        checks++; if (out_valid[i] !== (msz[i] > 0)) begin
          errors++; $display("FAIL rand_valid[%0d] n=%0d got %0b want %0b", i, n, out_valid[i], msz[i] > 0); end
        checks++; if (out_data[i] !== exp_data(i)) begin
          errors++; $display("FAIL rand_data[%0d] n=%0d got %h want %h", i, n, out_data[i], exp_data(i)); end
        checks++; if (occupancy[i] !== 2'(msz[i])) begin
          errors++; $display("FAIL rand_occ[%0d] n=%0d got %0d want %0d", i, n, occupancy[i], msz[i]); end
        checks++; if (in_ready[i] !== exp_ready(i)) begin
          errors++; $display("FAIL rand_ready[%0d] n=%0d got %0b want %0b", i, n, in_ready[i], exp_ready(i)); end
        checks++; if (stall_cnt[i] !== 32'(mcnt[i])) begin
          errors++; $display("FAIL rand_cnt[%0d] n=%0d got %0d want %0d", i, n, stall_cnt[i], mcnt[i]); end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      msz[i] = 0; mlast[i] = '0; mcnt[i] = 0; mf[i][0] = '0; mf[i][1] = '0;
    end
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_counter();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
